// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the SIPO deserializer slice.
//   state_t       : FSM encoding (IDLE=0, SHIFT=1)
//   DEFAULT_WIDTH : default frame width in bits
//   clog2()       : constant function used to size the bit counter
package sipo_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sipo_deserializer_shreg.sv
// WIDTH-bit shift register for the SIPO deserializer.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   clr     : synchronous clear (has priority over shift)
//   shift   : shift din into the register
//   din     : serial input bit
//   shifted : register contents with din shifted in (combinational),
//             i.e. the value the register takes on a shift edge
// MSB_FIRST=1 shifts left (din enters bit 0); MSB_FIRST=0 shifts right
// (din enters bit WIDTH-1).
module sipo_shreg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] q;

  always_comb begin
    shifted = q;
    if (MSB_FIRST) begin
      shifted = {q[WIDTH-2:0], din};
    end else begin
      shifted = {din, q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer.
// Assembles WIDTH-bit words from a strobed serial bit stream.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   din        : serial data bit
//   din_en     : bit strobe, din sampled only when 1 (and in SHIFT)
//   start      : frame start / restart request
//   dout       : last completed word (held until next completion)
//   dout_valid : one-cycle pulse, dout updated at this edge
//   busy       : 1 while a frame is being assembled
//   frame_err  : one-cycle pulse, a partial frame was aborted by start
//   bit_cnt    : bits accepted in the current frame
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter  bit          MSB_FIRST = 1'b1,
  localparam int unsigned CNTW      = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err,
  output logic [CNTW-1:0]  bit_cnt
);

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNTW-1:0]  cnt_n;
  logic [WIDTH-1:0] dout_n;
  logic             valid_n;
  logic             err_n;
  logic             sh_clr;
  logic             sh_en;
  logic [WIDTH-1:0] shifted;

  sipo_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .clr     (sh_clr),
    .shift   (sh_en),
    .din     (din),
    .shifted (shifted)
  );

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    dout_n  = dout;
    valid_n = 1'b0;
    err_n   = 1'b0;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    unique case (state)
      IDLE: begin
        // Strobes are ignored here, including one coincident with start.
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (din_en && (bit_cnt == LAST_BIT)) begin
          // Final bit wins over start: the word completes, and a
          // coincident start opens the next frame without an idle cycle.
          dout_n  = shifted;
          valid_n = 1'b1;
          cnt_n   = '0;
          sh_clr  = 1'b1;
          state_n = start ? SHIFT : IDLE;
        end else if (start) begin
          err_n  = (bit_cnt != '0);
          cnt_n  = '0;
          sh_clr = 1'b1;
        end else if (din_en) begin
          sh_en = 1'b1;
          cnt_n = bit_cnt + CNTW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         din;
  logic         din_en;
  logic         start;

  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l;
  logic         busy_m, busy_l;
  logic         err_m, err_l;
  logic [3:0]   cnt_m, cnt_l;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .start(start),
    .dout(dout_m), .dout_valid(valid_m), .busy(busy_m),
    .frame_err(err_m), .bit_cnt(cnt_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .start(start),
    .dout(dout_l), .dout_valid(valid_l), .busy(busy_l),
    .frame_err(err_l), .bit_cnt(cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is just the list of bits received so far.
  bit           m_busy = 1'b0;
  bit           bits[$];
  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];
  logic [W-1:0] last_m = '0;
  logic [W-1:0] last_l = '0;
  int           err_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_of(input bit q[$], input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) w[W-1-i] = q[i];
      else           w[i]     = q[i];
    end
    return w;
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_busy = 1'b0;
      bits.delete();
      exp_m.delete();
      exp_l.delete();
      last_m = '0;
      last_l = '0;
      err_pend = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        bits.delete();
      end
    end else if (din_en && bits.size() == W - 1) begin
      bits.push_back(din);
      last_m = word_of(bits, 1'b1);
      last_l = word_of(bits, 1'b0);
      exp_m.push_back(last_m);
      exp_l.push_back(last_l);
      bits.delete();
      m_busy = start;
    end else if (start) begin
      if (bits.size() != 0) err_pend++;
      bits.delete();
    end else if (din_en) begin
      bits.push_back(din);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  // Monitor: compare both instances against the model on every falling edge.
  int err_seen;
  initial begin
    forever begin
      @(negedge clk);
      err_seen = 0;
      if (valid_m) begin
        if (exp_m.size() == 0) check("unexpected_valid_msb", 1, 0);
        else check("word_msb", dout_m, exp_m.pop_front());
      end else if (exp_m.size() != 0) begin
        check("missed_valid_msb", 0, 1);
        void'(exp_m.pop_front());
      end
      if (valid_l) begin
        if (exp_l.size() == 0) check("unexpected_valid_lsb", 1, 0);
        else check("word_lsb", dout_l, exp_l.pop_front());
      end else if (exp_l.size() != 0) begin
        check("missed_valid_lsb", 0, 1);
        void'(exp_l.pop_front());
      end
      check("frame_err_msb", err_m, (err_pend != 0) ? 1 : 0);
      check("frame_err_lsb", err_l, (err_pend != 0) ? 1 : 0);
      if (err_pend != 0) err_pend--;
      check("hold_dout_msb", dout_m, last_m);
      check("hold_dout_lsb", dout_l, last_l);
      check("busy_msb", busy_m, m_busy);
      check("busy_lsb", busy_l, m_busy);
      check("bit_cnt_msb", cnt_m, bits.size());
      check("bit_cnt_lsb", cnt_l, bits.size());
      check("valid_err_excl", valid_m & err_m, 0);
    end
  end

  task automatic cyc(input logic s, input logic en, input logic d);
    @(negedge clk);
    #1;
    start  = s;
    din_en = en;
    din    = d;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic start_on_last);
    for (int i = W - 1; i >= 0; i--) begin
      cyc((i == 0) && start_on_last, 1'b1, w[i]);
    end
  endtask

  task automatic frame(input logic [W-1:0] w);
    cyc(1'b1, 1'b0, 1'b0);
    send_word(w, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; din = 1'b0; din_en = 1'b0; start = 1'b0;
    #12;
    check("reset_dout", dout_m, 0);
    check("reset_busy", busy_m, 0);
    check("reset_cnt", cnt_m, 0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Basic frame 1,0,1,1,0,0,1,0
    frame(8'hB2);
    check("basic_msb", dout_m, 8'hB2);
    check("basic_lsb", dout_l, 8'h4D);

    // Strobes with random gaps, all ones
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < W; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("gaps_msb", dout_m, 8'hFF);

    // Strobes while idle are ignored
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("idle_busy", busy_m, 0);
    check("idle_dout", dout_m, 8'hFF);

    // Abort after three bits, then restart with 0x0F
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("abort_err", err_m, 1);
    check("abort_cnt", cnt_m, 0);
    send_word(8'h0F, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("abort_msb", dout_m, 8'h0F);
    check("abort_lsb", dout_l, 8'hF0);

    // Back-to-back frames: start on the final-bit edge of the first
    cyc(1'b1, 1'b0, 1'b0);
    send_word(8'hA5, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("b2b_first", dout_m, 8'hA5);
    check("b2b_busy", busy_m, 1);
    send_word(8'h3C, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("b2b_second", dout_m, 8'h3C);

    // Asynchronous reset mid-frame
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_dout", dout_m, 0);
    check("arst_busy", busy_m, 0);
    check("arst_cnt", cnt_m, 0);
    check("arst_valid", valid_m, 0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b0, 1'b0);
    check("post_reset_no_frame", dout_m, 0);
    frame(8'h81);
    check("post_reset_msb", dout_m, 8'h81);
    check("post_reset_lsb", dout_l, 8'h81);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    check("queue_empty", exp_m.size() + exp_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Downstream consumer of the DFF stage.
- Takes the registered serial bit stream (DFF Q) plus a bit strobe and assembles WIDTH-bit parallel words.
- Presents each completed word with a one-cycle valid pulse and flags aborted frames.
- Sits between the flip-flop capture stage and word-level logic (parity check, display, counters).

Parameters:
- WIDTH, 8, number of bits per frame (>=2).
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  1  serial data bit, driven from the DFF Q output.
- din_en  input  1  bit strobe; din is sampled only on edges where din_en=1.
- start  input  1  frame start/restart request.
- dout  output  WIDTH  last completed word.
- dout_valid  output  1  one-cycle pulse: dout was updated at this edge.
- busy  output  1  1 while in SHIFT.
- frame_err  output  1  one-cycle pulse: partial frame aborted by start.
- bit_cnt  output  CNTW  bits accepted in current frame; CNTW = clog2(WIDTH+1).

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE; shift register, dout, bit_cnt = 0; dout_valid, frame_err, busy = 0.
  - Reset mid-frame discards the partial word.
  - No dout_valid or frame_err after release.
- All outputs are registered; busy = (state==SHIFT).
- IDLE:
  - din_en ignored.
  - start=1 -> SHIFT; bit_cnt=0; shift register cleared.
  - A din_en coincident with start is NOT captured; the first bit is the first din_en strictly after the start edge.
- SHIFT, din_en=1 and bit_cnt < WIDTH-1:
  - Shift din in (MSB_FIRST=1: shift left, din into bit 0; MSB_FIRST=0: shift right, din into bit WIDTH-1).
  - bit_cnt++.
- SHIFT, din_en=1 and bit_cnt == WIDTH-1 (final bit):
  - On the same edge: dout <= assembled word including this bit; dout_valid <= 1; bit_cnt <= 0; state <= IDLE.
  - Latency: dout_valid high during the clock period immediately following the edge that samples the last bit.
- SHIFT, din_en=0: hold everything; gaps of any length are allowed; no timeout.
- start during SHIFT, not on the final-bit edge:
  - Abort; frame_err=1 for one cycle if bit_cnt != 0 (0 if bit_cnt == 0).
  - Restart: bit_cnt=0, shift register cleared, stay in SHIFT.
  - dout and dout_valid unchanged (dout_valid=0).
- start coincident with the final-bit edge:
  - Word completes normally (dout_valid=1, no frame_err).
  - Next frame begins: state=SHIFT, bit_cnt=0. Back-to-back frames need no idle cycle.
- dout holds its value until the next completion; never cleared except by reset.
- dout_valid and frame_err are never both 1 in the same cycle.
- bit_cnt never exceeds WIDTH-1 in SHIFT; wrap to 0 occurs only on completion or abort.

Decomposition:
- Shared header (`include'd):
  - State encodings IDLE=1'b0, SHIFT=1'b1.
  - Clog2 constant function for CNTW.
  - Default WIDTH.
- One sub-module, sipo_shreg:
  - WIDTH-bit shift register with synchronous clear, shift enable, and direction parameter.
  - Async active-low rst.
- The FSM, counter and output registers stay in sipo_deserializer.

Test Plan:
- WIDTH=8, MSB_FIRST=1: pulse start, then bits 1,0,1,1,0,0,1,0 on consecutive din_en -> dout=8'hB2, dout_valid high exactly one cycle after 8th bit edge, busy drops same edge.
- Same stream, MSB_FIRST=0 -> dout=8'h4D.
- Gaps and idle strobes:
  - din_en toggling 1/0 with random gaps, bits all 1 -> dout=8'hFF only after 8th strobe; bit_cnt steps 0..7 then 0.
  - din_en pulses in IDLE -> no change.
- Abort: start, 3 bits (1,1,1), start again, then 8 bits 0x0F pattern -> frame_err one-cycle pulse at restart, bit_cnt=0, final dout=8'h0F, no dout_valid for the aborted frame.
- Back-to-back: start asserted on the 8th-bit edge of frame A (0xA5), then frame B (0x3C) -> dout_valid pulses for 0xA5 then 0x3C, no frame_err, busy stays 1 across boundary.
- Reset: rst=0 asynchronously after 5 bits (mid clock period) -> all outputs 0 immediately. After release plus 8 strobes without start -> no dout_valid. Then a normal frame 0x81 -> dout=8'h81.
